alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 143 ++++++++++++++
 tb/tb_alu_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus bit-serial multiply and
// restoring divide, with a valid/ready request side and a valid/ready result side.
module alu_seq #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   input  logic [3:0]      i_op,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_res,
   output logic            o_busy
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
      OP_OR, OP_AND, OP_MUL, OP_MULHU, OP_DIVU, OP_REMU, OP_DIV, OP_REM
   } op_t;

   state_t          state, stateNext;
   op_t             opReg;
   logic [XLEN-1:0] aReg, bReg, hiReg, loReg;
   logic [XLEN-1:0] hiNext, loNext, singleRes, finalRes, divisor, dividendIn;
   logic [XLEN:0]   sum, shifted;
   logic [CW-1:0]   cnt;
   logic [SHW-1:0]  shamt;
   logic            readyEn, accept, lastStep, isIter, isMul, signedDiv, bZero;

   // readyEn keeps o_ready low during reset and until the first edge after release
   assign o_ready  = (state == IDLE) && readyEn;
   assign o_valid  = (state == DONE);
   assign o_busy   = (state == CALC);
   assign accept   = i_valid && o_ready;
   assign lastStep = (cnt == CW'(XLEN - 1));
   assign isIter   = (i_op >= 4'd10);
   assign shamt    = i_b[SHW-1:0];

   // Single-cycle results, computed straight from the request inputs
   always_comb begin
      singleRes = '0;
      unique case (op_t'(i_op))
         OP_ADD:  singleRes = i_a + i_b;
         OP_SUB:  singleRes = i_a - i_b;
         OP_SLL:  singleRes = i_a << shamt;
         OP_SLT:  singleRes = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
         OP_SLTU: singleRes = {{(XLEN-1){1'b0}}, i_a < i_b};
         OP_XOR:  singleRes = i_a ^ i_b;
         OP_SRL:  singleRes = i_a >> shamt;
         OP_SRA:  singleRes = $signed(i_a) >>> shamt;
         OP_OR:   singleRes = i_a | i_b;
         OP_AND:  singleRes = i_a & i_b;
         default: singleRes = '0;
      endcase
      dividendIn = ((i_op == OP_DIV || i_op == OP_REM) && i_a[XLEN-1]) ? -i_a : i_a;
   end

   // One iteration: multiply shifts the multiplier out of loReg while the product
   // grows in hiReg; divide shifts the dividend out of loReg and the quotient in
   always_comb begin
      isMul     = (opReg == OP_MUL) || (opReg == OP_MULHU);
      signedDiv = (opReg == OP_DIV) || (opReg == OP_REM);
      divisor   = (signedDiv && bReg[XLEN-1]) ? -bReg : bReg;
      bZero     = (bReg == '0);
      sum       = {1'b0, hiReg} + (loReg[0] ? {1'b0, bReg} : '0);
      shifted   = {hiReg, loReg[XLEN-1]};
      hiNext    = hiReg;
      loNext    = loReg;
      if (isMul) begin
         hiNext = sum[XLEN:1];
         loNext = {sum[0], loReg[XLEN-1:1]};
      end else if (shifted >= {1'b0, divisor}) begin
         hiNext = shifted[XLEN-1:0] - divisor;
         loNext = {loReg[XLEN-2:0], 1'b1};
      end else begin
         hiNext = shifted[XLEN-1:0];
         loNext = {loReg[XLEN-2:0], 1'b0};
      end
   end

   // Sign fix-up and divide-by-zero handling applied to the final iteration
   always_comb begin
      finalRes = '0;
      unique case (opReg)
         OP_MUL:   finalRes = loNext;
         OP_MULHU: finalRes = hiNext;
         OP_DIVU:  finalRes = bZero ? '1 : loNext;
         OP_REMU:  finalRes = bZero ? aReg : hiNext;
         OP_DIV:   finalRes = bZero ? '1 : ((aReg[XLEN-1] ^ bReg[XLEN-1]) ? -loNext : loNext);
         OP_REM:   finalRes = bZero ? aReg : (aReg[XLEN-1] ? -hiNext : hiNext);
         default:  finalRes = '0;
      endcase
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    if (accept) stateNext = isIter ? CALC : DONE;
         CALC:    if (lastStep) stateNext = DONE;
         DONE:    if (i_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         readyEn <= 1'b0;
         opReg   <= OP_ADD;
         aReg    <= '0;
         bReg    <= '0;
         hiReg   <= '0;
         loReg   <= '0;
         cnt     <= '0;
         o_res   <= '0;
      end else begin
         state   <= stateNext;
         readyEn <= 1'b1;
         if (accept) begin
            opReg <= op_t'(i_op);
            aReg  <= i_a;
            bReg  <= i_b;
            hiReg <= '0;
            loReg <= (i_op == OP_MUL || i_op == OP_MULHU) ? i_a : dividendIn;
            cnt   <= '0;
            if (!isIter) o_res <= singleRes;
         end else if (state == CALC) begin
            hiReg <= hiNext;
            loReg <= loNext;
            cnt   <= cnt + 1'b1;
            if (lastStep) o_res <= finalRes;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed 32-bit vectors and corner sequences, then a
// randomized 8-bit run against an arithmetic reference model.
module tb_alu_seq;

   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
      OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7, OP_OR = 4'd8,
      OP_AND = 4'd9, OP_MUL = 4'd10, OP_MULHU = 4'd11, OP_DIVU = 4'd12,
      OP_REMU = 4'd13, OP_DIV = 4'd14, OP_REM = 4'd15;
   localparam int RAND_REQS = 4000;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst32n, v32, rdy32, ordy32, ov32, busy32;
   logic [31:0] a32, b32, res32;
   logic [3:0]  op32;
   logic        rst8n, v8, rdy8, ordy8, ov8, busy8;
   logic [7:0]  a8, b8, res8;
   logic [3:0]  op8;

   int total = 0;
   int bad = 0;
   vec_t vecs[$];
   logic [7:0] expQ[$];

   alu_seq #(.XLEN(32)) dut32 (
      .i_clk(clk), .i_rst_n(rst32n), .i_valid(v32), .o_ready(ordy32),
      .i_a(a32), .i_b(b32), .i_op(op32), .o_valid(ov32), .i_ready(rdy32),
      .o_res(res32), .o_busy(busy32)
   );

   alu_seq #(.XLEN(8)) dut8 (
      .i_clk(clk), .i_rst_n(rst8n), .i_valid(v8), .o_ready(ordy8),
      .i_a(a8), .i_b(b8), .i_op(op8), .o_valid(ov8), .i_ready(rdy8),
      .o_res(res8), .o_busy(busy8)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic addVec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.exp = exp;
      vecs.push_back(v);
   endtask

   // Issue one request on the 32-bit instance, scramble the inputs after accept,
   // and wait for the result; optionally complete the output handshake
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input bit handshake, output logic [31:0] res,
                                output int lat, output int busyCnt);
      int guard = 0;
      @(negedge clk);
      while (!ordy32 && guard < 200) begin @(negedge clk); guard++; end
      op32 = op; a32 = a; b32 = b; v32 = 1'b1;
      @(negedge clk);
      v32 = 1'b0; a32 = $urandom; b32 = $urandom; op32 = 4'($urandom);
      lat = 1; busyCnt = 0;
      while (!ov32 && lat < 200) begin
         if (busy32) busyCnt++;
         @(negedge clk);
         lat++;
      end
      res = res32;
      if (handshake) begin
         rdy32 = 1'b1;
         @(negedge clk);
         rdy32 = 1'b0;
      end
   endtask

   // Reference behaviour for XLEN=8 using plain integer arithmetic
   function automatic logic [7:0] refModel(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      int sa = int'($signed(a));
      int sb = int'($signed(b));
      int ua = int'({24'd0, a});
      int ub = int'({24'd0, b});
      int sh = int'({29'd0, b[2:0]});
      case (op)
         OP_ADD:   return 8'(ua + ub);
         OP_SUB:   return 8'(ua - ub);
         OP_SLL:   return 8'(ua << sh);
         OP_SLT:   return (sa < sb) ? 8'd1 : 8'd0;
         OP_SLTU:  return (ua < ub) ? 8'd1 : 8'd0;
         OP_XOR:   return a ^ b;
         OP_SRL:   return 8'(ua >> sh);
         OP_SRA:   return 8'(sa >>> sh);
         OP_OR:    return a | b;
         OP_AND:   return a & b;
         OP_MUL:   return 8'(ua * ub);
         OP_MULHU: return 8'((ua * ub) >> 8);
         OP_DIVU:  return (ub == 0) ? 8'hFF : 8'(ua / ub);
         OP_REMU:  return (ub == 0) ? a : 8'(ua % ub);
         OP_DIV:   return (ub == 0) ? 8'hFF : ((sa == -128 && sb == -1) ? 8'h80 : 8'(sa / sb));
         default:  return (ub == 0) ? a : ((sa == -128 && sb == -1) ? 8'h00 : 8'(sa % sb));
      endcase
   endfunction

   initial begin
      logic [31:0] res;
      int lat, busyCnt, accepted, received, cyc;

      rst32n = 1'b0; v32 = 1'b0; rdy32 = 1'b0; a32 = '0; b32 = '0; op32 = '0;
      rst8n = 1'b0; v8 = 1'b0; rdy8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_ready", ordy32, 0);
      checkOutput("rst_valid", ov32, 0);
      checkOutput("rst_busy", busy32, 0);
      checkOutput("rst_res", res32, 0);
      checkOutput("rst_ready8", ordy8, 0);
      rst32n = 1'b1; rst8n = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_rst", ordy32, 1);
      checkOutput("ready_after_rst8", ordy8, 1);

      addVec(OP_ADD,   32'hFFFFFFFF, 32'd1,        32'd0);
      addVec(OP_SUB,   32'd0,        32'd1,        32'hFFFFFFFF);
      addVec(OP_SLL,   32'd1,        32'h21,       32'd2);
      addVec(OP_SLT,   32'hFFFFFFFF, 32'd1,        32'd1);
      addVec(OP_SLTU,  32'hFFFFFFFF, 32'd1,        32'd0);
      addVec(OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
      addVec(OP_SRL,   32'h80000000, 32'h24,       32'h08000000);
      addVec(OP_SRA,   32'h80000000, 32'h24,       32'hF8000000);
      addVec(OP_OR,    32'h000000F0, 32'h00000F00, 32'h00000FF0);
      addVec(OP_AND,   32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00);
      addVec(OP_MUL,   32'h10000,    32'h10000,    32'd0);
      addVec(OP_MULHU, 32'h10000,    32'h10000,    32'd1);
      addVec(OP_MUL,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
      addVec(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
      addVec(OP_DIVU,  32'd100,      32'd7,        32'd14);
      addVec(OP_REMU,  32'd100,      32'd7,        32'd2);
      addVec(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
      addVec(OP_REM,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
      addVec(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD);
      addVec(OP_REM,   32'd7,        32'hFFFFFFFE, 32'd1);
      addVec(OP_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF);
      addVec(OP_REMU,  32'd5,        32'd0,        32'd5);
      addVec(OP_DIV,   32'd5,        32'd0,        32'hFFFFFFFF);
      addVec(OP_REM,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB);
      addVec(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000);
      addVec(OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'd0);
      addVec(OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, res, lat, busyCnt);
         checkOutput($sformatf("vec%0d_res", i), res, vecs[i].exp);
         checkOutput($sformatf("vec%0d_lat", i), lat, (vecs[i].op >= 4'd10) ? 33 : 1);
         checkOutput($sformatf("vec%0d_busy", i), busyCnt, (vecs[i].op >= 4'd10) ? 32 : 0);
      end

      // Result must hold under backpressure while new requests are offered
      applyStimulus(OP_MUL, 32'h12345, 32'h100, 1'b0, res, lat, busyCnt);
      checkOutput("bp_first", res, 32'h01234500);
      for (int k = 0; k < 5; k++) begin
         v32 = ~v32; a32 = $urandom; b32 = $urandom; op32 = OP_ADD;
         @(negedge clk);
         checkOutput($sformatf("bp%0d_res", k), res32, 32'h01234500);
         checkOutput($sformatf("bp%0d_ready", k), ordy32, 0);
         checkOutput($sformatf("bp%0d_valid", k), ov32, 1);
      end
      v32 = 1'b1; op32 = OP_ADD; a32 = 32'd1; b32 = 32'd1; rdy32 = 1'b1;
      @(negedge clk);
      v32 = 1'b0; rdy32 = 1'b0;
      checkOutput("bp_release_valid", ov32, 0);
      checkOutput("bp_release_ready", ordy32, 1);
      @(negedge clk);
      checkOutput("no_accept_in_done", ov32, 0);

      // Asynchronous reset ten cycles into a divide
      op32 = OP_DIVU; a32 = 32'd1000; b32 = 32'd3; v32 = 1'b1;
      @(negedge clk);
      v32 = 1'b0;
      repeat (9) @(negedge clk);
      checkOutput("midop_busy", busy32, 1);
      #2 rst32n = 1'b0;
      #1;
      checkOutput("midop_rst_valid", ov32, 0);
      checkOutput("midop_rst_res", res32, 0);
      checkOutput("midop_rst_busy", busy32, 0);
      checkOutput("midop_rst_ready", ordy32, 0);
      repeat (2) @(negedge clk);
      rst32n = 1'b1;
      @(negedge clk);
      checkOutput("midop_ready_after", ordy32, 1);
      applyStimulus(OP_ADD, 32'd3, 32'd4, 1'b1, res, lat, busyCnt);
      checkOutput("post_rst_add", res, 32'd7);
      checkOutput("post_rst_lat", lat, 1);

      // Randomized 8-bit run with random request and consume handshakes
      accepted = 0; received = 0; cyc = 0;
      while ((accepted < RAND_REQS || expQ.size() != 0) && cyc < 90000) begin
         v8 = (accepted < RAND_REQS) && ($urandom_range(0, 3) != 0);
         op8 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
         case ($urandom_range(0, 7))
            0: b8 = 8'd0;
            1: begin a8 = 8'h80; b8 = 8'hFF; end
            default: ;
         endcase
         rdy8 = ($urandom_range(0, 2) != 0);
         if (v8 && ordy8) begin
            expQ.push_back(refModel(op8, a8, b8));
            accepted++;
         end
         if (ov8 && rdy8) begin
            if (expQ.size() == 0) checkOutput("rand_dup", 1, 0);
            else checkOutput($sformatf("rand%0d", received), res8, expQ.pop_front());
            received++;
         end
         @(negedge clk);
         cyc++;
      end
      v8 = 1'b0; rdy8 = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rand_count", received, accepted);
      checkOutput("rand_accepted", accepted, RAND_REQS);
      checkOutput("rand_pending", expQ.size(), 0);
      checkOutput("rand_extra_valid", ov8, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
